// File: rtl/ps2_kbd_cmd_ctrl.sv
// ps2_kbd_cmd_ctrl
// Host-side PS/2 command sequencer for the keyboard link.
//   - Drives the open-drain clock/data pulls and serialises command bytes
//     (inhibit, request-to-send, 8 data bits LSB first, odd parity, stop, ACK).
//   - Consumes device responses (FA/FE/AA/FC) from the external byte receiver
//     and asserts rx_owned while doing so, so the key translator ignores them.
//   - Runs the keyboard reset/self-test (FF) sequence automatically after RST.
// Optional build macro: LED_MIRROR_EN adds led_state[2:0] and self-issues
//   ED + {5'b0, led_state} whenever the LED state changes while idle.
// Ports:
//   CLK, RST            100 MHz clock, asynchronous active-high reset
//   ps2c_in, ps2d_in    PS/2 pin states
//   ps2c_oe, ps2d_oe    1 = pull the PS/2 clock / data line low
//   rx_byte, rx_valid   byte strobe from the PS/2 receiver
//   cmd_req, cmd_byte,
//   has_arg, arg_byte   command request (level, sampled only when idle)
//   busy, done, err     status; done/err are one-cycle pulses
//   init_ok             keyboard passed self-test (AA seen)
//   rx_owned            controller is consuming receiver bytes
module ps2_kbd_cmd_ctrl #(
    parameter int INHIBIT_CYC      = 12000,
    parameter int TX_TIMEOUT_CYC   = 200000,
    parameter int RESP_TIMEOUT_CYC = 2000000,
    parameter int BAT_TIMEOUT_CYC  = 75000000,
    parameter int MAX_RETRY        = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       cmd_req,
    input  logic [7:0] cmd_byte,
    input  logic       has_arg,
    input  logic [7:0] arg_byte,
`ifdef LED_MIRROR_EN
    input  logic [2:0] led_state,
`endif
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       init_ok,
    output logic       rx_owned
);

    localparam int TW = 27;
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYC - 1);
    localparam logic [TW-1:0] TX_LAST   = TW'(TX_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] RESP_LAST = TW'(RESP_TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] BAT_LAST  = TW'(BAT_TIMEOUT_CYC - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_INIT_LOAD, S_IDLE, S_INHIBIT, S_RTS, S_TX_BITS,
        S_TX_ACK, S_WAIT_RESP, S_WAIT_BAT, S_DONE, S_ERR
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      c_sync_q, c_sync_d;
    logic [1:0]      d_sync_q, d_sync_d;
    logic [7:0]      flt_q, flt_d;
    logic            filt_q, filt_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [7:0]      cmd_q, cmd_d;
    logic [7:0]      arg_q, arg_d;
    logic [7:0]      cur_q, cur_d;
    logic            has_arg_q, has_arg_d;
    logic            arg_sent_q, arg_sent_d;
    logic            ps2c_oe_q, ps2c_oe_d;
    logic            ps2d_oe_q, ps2d_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            init_ok_q, init_ok_d;
    logic            rx_owned_q, rx_owned_d;
    logic            fall;
    logic            retry_event;
`ifdef LED_MIRROR_EN
    logic [2:0]      led_q, led_d;
    logic            led_auto_q, led_auto_d;
`endif

    // NOTE: every variable written here gets a default at the top so no
    // path through the case statement can leave one unassigned (latch).
    always_comb begin
        state_d     = state_q;
        c_sync_d    = {c_sync_q[0], ps2c_in};
        d_sync_d    = {d_sync_q[0], ps2d_in};
        flt_d       = {flt_q[6:0], c_sync_q[1]};
        tmr_d       = tmr_q + TW'(1);
        bit_cnt_d   = bit_cnt_q;
        retry_d     = retry_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        cur_d       = cur_q;
        has_arg_d   = has_arg_q;
        arg_sent_d  = arg_sent_q;
        ps2d_oe_d   = ps2d_oe_q;
        init_ok_d   = init_ok_q;
        retry_event = 1'b0;
`ifdef LED_MIRROR_EN
        led_d       = led_q;
        led_auto_d  = led_auto_q;
`endif

        // Filtered clock level only moves once 8 consecutive samples agree.
        if (flt_q == 8'hFF) begin
            filt_d = 1'b1;
        end else if (flt_q == 8'h00) begin
            filt_d = 1'b0;
        end else begin
            filt_d = filt_q;
        end
        fall = filt_q & ~filt_d;

        case (state_q)
            S_INIT_LOAD: begin
                cmd_d      = 8'hFF;
                cur_d      = 8'hFF;
                has_arg_d  = 1'b0;
                arg_sent_d = 1'b0;
                retry_d    = '0;
                state_d    = S_INHIBIT;
            end
            S_IDLE: begin
                if (cmd_req) begin
                    cmd_d      = cmd_byte;
                    cur_d      = cmd_byte;
                    has_arg_d  = has_arg;
                    arg_d      = arg_byte;
                    arg_sent_d = 1'b0;
                    retry_d    = '0;
                    state_d    = S_INHIBIT;
                    if (cmd_byte == 8'hFF) init_ok_d = 1'b0;
`ifdef LED_MIRROR_EN
                    led_auto_d = 1'b0;
`endif
                end
`ifdef LED_MIRROR_EN
                else if (init_ok_q && (led_state != led_q)) begin
                    cmd_d      = 8'hED;
                    cur_d      = 8'hED;
                    has_arg_d  = 1'b1;
                    arg_d      = {5'b0, led_state};
                    arg_sent_d = 1'b0;
                    retry_d    = '0;
                    led_auto_d = 1'b1;
                    state_d    = S_INHIBIT;
                end
`endif
            end
            S_INHIBIT: begin
                if (tmr_q == INH_LAST) state_d = S_RTS;
            end
            S_RTS: begin
                bit_cnt_d = '0;
                state_d   = S_TX_BITS;
            end
            S_TX_BITS: begin
                // A fall takes precedence over a timeout expiring in the same cycle.
                if (fall) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        ps2d_oe_d = ~cur_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        ps2d_oe_d = ^cur_q;          // pull low when odd parity bit is 0
                    end else begin
                        ps2d_oe_d = 1'b0;            // stop bit: line released
                        state_d   = S_TX_ACK;
                    end
                end else if (tmr_q == TX_LAST) begin
                    retry_event = 1'b1;
                end
            end
            S_TX_ACK: begin
                if (fall) begin
                    if (!d_sync_q[1]) state_d = S_WAIT_RESP;
                    else              retry_event = 1'b1;
                end else if (tmr_q == TX_LAST) begin
                    retry_event = 1'b1;
                end
            end
            S_WAIT_RESP: begin
                if (rx_valid) begin
                    if (rx_byte == 8'hFA) begin
                        if (has_arg_q && !arg_sent_q) begin
                            cur_d      = arg_q;
                            arg_sent_d = 1'b1;
                            retry_d    = '0;
                            state_d    = S_INHIBIT;
                        end else if (cmd_q == 8'hFF) begin
                            state_d = S_WAIT_BAT;
                        end else begin
                            state_d = S_DONE;
                        end
                    end else if (rx_byte == 8'hFE) begin
                        retry_event = 1'b1;
                    end
                end else if (tmr_q == RESP_LAST) begin
                    retry_event = 1'b1;
                end
            end
            S_WAIT_BAT: begin
                if (rx_valid) begin
                    if (rx_byte == 8'hAA) begin
                        init_ok_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (rx_byte == 8'hFC) begin
                        init_ok_d = 1'b0;
                        state_d   = S_ERR;
                    end
                end else if (tmr_q == BAT_LAST) begin
                    init_ok_d = 1'b0;
                    state_d   = S_ERR;
                end
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default:       state_d = S_INIT_LOAD;
        endcase

        // FE, NACK and timeouts all resend the byte currently in cur_q.
        if (retry_event) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + RW'(1);
                state_d = S_INHIBIT;
            end else begin
                state_d = S_ERR;
            end
        end

        // The inhibit window is timed from entry only: our own clock pull
        // produces a filtered fall there, which must not restart the count.
        if ((state_d != state_q) ||
            (fall && ((state_q == S_TX_BITS) || (state_q == S_TX_ACK)))) begin
            tmr_d = '0;
        end

        if (state_d == S_RTS)          ps2d_oe_d = 1'b1;
        else if (state_d != S_TX_BITS) ps2d_oe_d = 1'b0;

        ps2c_oe_d  = (state_d == S_INHIBIT);
        busy_d     = !(state_d inside {S_IDLE, S_DONE, S_ERR});
        rx_owned_d = (state_d inside {S_WAIT_RESP, S_WAIT_BAT});
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);

`ifdef LED_MIRROR_EN
        if ((state_d == S_DONE) && led_auto_q) led_d = arg_q[2:0];
`endif
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_INIT_LOAD;
            c_sync_q   <= 2'b11;
            d_sync_q   <= 2'b11;
            flt_q      <= 8'hFF;
            filt_q     <= 1'b1;
            tmr_q      <= '0;
            bit_cnt_q  <= '0;
            retry_q    <= '0;
            cmd_q      <= 8'hFF;
            arg_q      <= '0;
            cur_q      <= 8'hFF;
            has_arg_q  <= 1'b0;
            arg_sent_q <= 1'b0;
            ps2c_oe_q  <= 1'b0;
            ps2d_oe_q  <= 1'b0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            init_ok_q  <= 1'b0;
            rx_owned_q <= 1'b0;
`ifdef LED_MIRROR_EN
            led_q      <= 3'b000;
            led_auto_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            c_sync_q   <= c_sync_d;
            d_sync_q   <= d_sync_d;
            flt_q      <= flt_d;
            filt_q     <= filt_d;
            tmr_q      <= tmr_d;
            bit_cnt_q  <= bit_cnt_d;
            retry_q    <= retry_d;
            cmd_q      <= cmd_d;
            arg_q      <= arg_d;
            cur_q      <= cur_d;
            has_arg_q  <= has_arg_d;
            arg_sent_q <= arg_sent_d;
            ps2c_oe_q  <= ps2c_oe_d;
            ps2d_oe_q  <= ps2d_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            init_ok_q  <= init_ok_d;
            rx_owned_q <= rx_owned_d;
`ifdef LED_MIRROR_EN
            led_q      <= led_d;
            led_auto_q <= led_auto_d;
`endif
        end
    end

    assign ps2c_oe  = ps2c_oe_q;
    assign ps2d_oe  = ps2d_oe_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign init_ok  = init_ok_q;
    assign rx_owned = rx_owned_q;

endmodule

// File: tb/tb_ps2_kbd_cmd_ctrl.sv
// Testbench for ps2_kbd_cmd_ctrl: a PS/2 keyboard model clocks host frames
// in, checks them against an expected-frame queue, answers from a response
// queue, and a monitor checks done/err pulses against an expected-event queue.
module tb_ps2_kbd_cmd_ctrl;

    localparam int INH  = 100;
    localparam int TXTO = 600;
    localparam int RSTO = 2000;
    localparam int BATO = 3000;
    localparam int HALF = 40;

    typedef struct packed {
        logic [1:0]  n;
        logic [23:0] b;
    } resp_t;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ps2c_oe, ps2d_oe;
    logic       ps2c_line, ps2d_line;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       cmd_req;
    logic [7:0] cmd_byte;
    logic       has_arg;
    logic [7:0] arg_byte;
    logic       busy, done, err, init_ok, rx_owned;
    logic       dev_c, dev_d;
`ifdef LED_MIRROR_EN
    logic [2:0] led_state = 3'b000;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int dev_fall_cnt = 0;
    int rts_cnt = 0;
    int inh_run = 0;
    bit dev_mute = 1'b0;
    bit rst_evt  = 1'b0;

    logic [7:0] exp_frames [$];
    resp_t      resp_q     [$];
    logic [1:0] exp_evt    [$];   // 2'b10 = done, 2'b01 = err

    assign ps2c_line = dev_c & ~ps2c_oe;
    assign ps2d_line = dev_d & ~ps2d_oe;

    always #5 CLK = ~CLK;

    ps2_kbd_cmd_ctrl #(
        .INHIBIT_CYC     (INH),
        .TX_TIMEOUT_CYC  (TXTO),
        .RESP_TIMEOUT_CYC(RSTO),
        .BAT_TIMEOUT_CYC (BATO),
        .MAX_RETRY       (3)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .ps2c_in (ps2c_line),
        .ps2d_in (ps2d_line),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .cmd_req (cmd_req),
        .cmd_byte(cmd_byte),
        .has_arg (has_arg),
        .arg_byte(arg_byte),
`ifdef LED_MIRROR_EN
        .led_state(led_state),
`endif
        .busy    (busy),
        .done    (done),
        .err     (err),
        .init_ok (init_ok),
        .rx_owned(rx_owned)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic resp_t mk_resp(input logic [1:0] n, input logic [7:0] b0,
                                      input logic [7:0] b1, input logic [7:0] b2);
        resp_t r;
        r.n = n;
        r.b = {b2, b1, b0};
        return r;
    endfunction

    // Keyboard model: clocks one host frame, samples bits on rising edges,
    // ACKs on the 11th clock, then plays back the queued responses.
    task automatic dev_frame();
        logic [9:0] bits = '0;
        logic [9:0] exp10, got10;
        logic [7:0] eb;
        resp_t      r;
        bit         abort = 1'b0;
        repeat (50) @(negedge CLK);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_d = 1'b0;
            dev_c = 1'b0;
            dev_fall_cnt = k;
            repeat (HALF) @(negedge CLK);
            if (rst_evt) begin abort = 1'b1; break; end
            dev_c = 1'b1;
            if (k <= 10) bits[k-1] = ps2d_line;
            if (k == 5) check("owned_during_tx", {31'b0, rx_owned}, 0);
            repeat (HALF) @(negedge CLK);
            if (rst_evt) begin abort = 1'b1; break; end
        end
        dev_c = 1'b1;
        dev_d = 1'b1;
        dev_fall_cnt = 0;
        if (abort) begin
            rst_evt = 1'b0;
            return;
        end
        if (exp_frames.size() != 0) begin
            eb = exp_frames.pop_front();
            exp10 = {1'b0, ~^eb, eb};
        end else begin
            exp10 = 10'h3FF;
        end
        got10 = {1'b0, bits[8], bits[7:0]};
        check("frame", {22'b0, got10}, {22'b0, exp10});
        check("stop_bit", {31'b0, bits[9]}, 1);
        r = (resp_q.size() != 0) ? resp_q.pop_front() : mk_resp(2'd0, 8'h0, 8'h0, 8'h0);
        for (int i = 0; i < int'(r.n); i++) begin
            repeat (100) @(negedge CLK);
            check("owned_at_resp", {31'b0, rx_owned}, 1);
            rx_byte  = r.b[8*i +: 8];
            rx_valid = 1'b1;
            @(negedge CLK);
            rx_valid = 1'b0;
        end
    endtask

    initial begin : dev_model
        int dur;
        dev_c = 1'b1;
        dev_d = 1'b1;
        rx_valid = 1'b0;
        rx_byte = 8'h00;
        forever begin
            @(negedge CLK);
            if (!RST && ps2c_line && !ps2d_line) begin
                if (dev_mute) begin
                    rts_cnt++;
                    dur = 0;
                    while (ps2d_oe && dur < 5000) begin
                        @(negedge CLK);
                        dur++;
                    end
                    check("tx_timeout_release", dur, TXTO + 1);
                end else begin
                    dev_frame();
                end
            end
        end
    end

    // done/err pulses are matched against the expected-event queue.
    always @(negedge CLK) begin
        logic [1:0] code, exp;
        if (!RST && (done || err)) begin
            code = {done, err};
            exp  = (exp_evt.size() != 0) ? exp_evt.pop_front() : 2'b00;
            check("event", {30'b0, code}, {30'b0, exp});
            check("busy_at_end", {31'b0, busy}, 0);
            check("owned_at_end", {31'b0, rx_owned}, 0);
        end
    end

    // Every clock-inhibit window must last exactly INH cycles.
    always @(negedge CLK) begin
        if (ps2c_oe) begin
            inh_run++;
        end else begin
            if (inh_run != 0) check("inhibit_len", inh_run, INH);
            inh_run = 0;
        end
    end

    task automatic send_cmd(input logic [7:0] c, input logic ha, input logic [7:0] a);
        @(negedge CLK);
        cmd_byte = c;
        has_arg  = ha;
        arg_byte = a;
        cmd_req  = 1'b1;
        @(negedge CLK);
        cmd_req  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy !== 1'b0 && n < max_cyc) begin
            @(negedge CLK);
            n++;
        end
        if (busy !== 1'b0) check("idle_timeout", {31'b0, busy}, 0);
        repeat (5) @(negedge CLK);
    endtask

    initial begin : watchdog
        repeat (80000) @(negedge CLK);
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        RST = 1'b1;
        cmd_req = 1'b0;
        cmd_byte = 8'h00;
        has_arg = 1'b0;
        arg_byte = 8'h00;

        // Power-up: FF frame, FA, a stray byte during self-test, then AA.
        exp_frames.push_back(8'hFF);
        resp_q.push_back(mk_resp(2'd3, 8'hFA, 8'h11, 8'hAA));
        exp_evt.push_back(2'b10);
        repeat (5) @(negedge CLK);
        check("rst_ps2c_oe",  {31'b0, ps2c_oe},  0);
        check("rst_ps2d_oe",  {31'b0, ps2d_oe},  0);
        check("rst_done",     {31'b0, done},     0);
        check("rst_err",      {31'b0, err},      0);
        check("rst_init_ok",  {31'b0, init_ok},  0);
        check("rst_rx_owned", {31'b0, rx_owned}, 0);
        check("rst_busy",     {31'b0, busy},     1);
        RST = 1'b0;
        wait_idle(20000);
        check("init_ok_after_bat", {31'b0, init_ok}, 1);
        check("idle_ps2c_oe", {31'b0, ps2c_oe}, 0);

        // ED + 02 with a second request arriving while busy (ignored).
        exp_frames.push_back(8'hED);
        exp_frames.push_back(8'h02);
        resp_q.push_back(mk_resp(2'd1, 8'hFA, 8'h0, 8'h0));
        resp_q.push_back(mk_resp(2'd1, 8'hFA, 8'h0, 8'h0));
        exp_evt.push_back(2'b10);
        send_cmd(8'hED, 1'b1, 8'h02);
        repeat (300) @(negedge CLK);
        send_cmd(8'hF5, 1'b0, 8'h00);
        wait_idle(20000);
        check("init_ok_kept", {31'b0, init_ok}, 1);

        // F4 refused three times, accepted on the fourth send.
        for (int i = 0; i < 4; i++) exp_frames.push_back(8'hF4);
        for (int i = 0; i < 3; i++) resp_q.push_back(mk_resp(2'd1, 8'hFE, 8'h0, 8'h0));
        resp_q.push_back(mk_resp(2'd1, 8'hFA, 8'h0, 8'h0));
        exp_evt.push_back(2'b10);
        send_cmd(8'hF4, 1'b0, 8'h00);
        wait_idle(20000);

        // F4 refused four times: retries exhausted.
        for (int i = 0; i < 4; i++) exp_frames.push_back(8'hF4);
        for (int i = 0; i < 4; i++) resp_q.push_back(mk_resp(2'd1, 8'hFE, 8'h0, 8'h0));
        exp_evt.push_back(2'b01);
        send_cmd(8'hF4, 1'b0, 8'h00);
        wait_idle(20000);
        check("frames_left_fe4", exp_frames.size(), 0);

        // Silent device: every attempt times out in TX_BITS.
        dev_mute = 1'b1;
        rts_cnt = 0;
        exp_evt.push_back(2'b01);
        send_cmd(8'hF4, 1'b0, 8'h00);
        wait_idle(20000);
        dev_mute = 1'b0;
        check("rts_attempts", rts_cnt, 4);
        check("idle_ps2c_rel", {31'b0, ps2c_oe}, 0);
        check("idle_ps2d_rel", {31'b0, ps2d_oe}, 0);

        // Reset at fall 5 of an EE frame: d4 of EE is 0, so data is pulled.
        send_cmd(8'hEE, 1'b0, 8'h00);
        n = 0;
        while (dev_fall_cnt != 5 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check("reached_fall5", dev_fall_cnt, 5);
        repeat (20) @(negedge CLK);
        check("pre_rst_ps2d_oe", {31'b0, ps2d_oe}, 1);
        #1 RST = 1'b1;
        rst_evt = 1'b1;
        #1;
        check("async_ps2c_rel", {31'b0, ps2c_oe}, 0);
        check("async_ps2d_rel", {31'b0, ps2d_oe}, 0);
        check("async_busy", {31'b0, busy}, 1);
        check("async_init_ok", {31'b0, init_ok}, 0);
        exp_frames.push_back(8'hFF);
        resp_q.push_back(mk_resp(2'd2, 8'hFA, 8'hAA, 8'h0));
        exp_evt.push_back(2'b10);
        repeat (5) @(negedge CLK);
        RST = 1'b0;
        wait_idle(20000);
        check("init_ok_after_rerun", {31'b0, init_ok}, 1);

`ifdef LED_MIRROR_EN
        // LED change and cmd_req in the same idle cycle: request first.
        exp_frames.push_back(8'hF4);
        exp_frames.push_back(8'hED);
        exp_frames.push_back(8'h05);
        for (int i = 0; i < 3; i++) resp_q.push_back(mk_resp(2'd1, 8'hFA, 8'h0, 8'h0));
        exp_evt.push_back(2'b10);
        exp_evt.push_back(2'b10);
        @(negedge CLK);
        led_state = 3'b101;
        cmd_byte  = 8'hF4;
        has_arg   = 1'b0;
        cmd_req   = 1'b1;
        @(negedge CLK);
        cmd_req   = 1'b0;
        wait_idle(20000);
        wait_idle(20000);
        repeat (200) @(negedge CLK);
        check("led_no_reissue", {31'b0, busy}, 0);
`endif

        check("frames_left", exp_frames.size(), 0);
        check("resp_left", resp_q.size(), 0);
        check("events_left", exp_evt.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
